// File: rtl/regfile_lane_sb.sv
// Dual write-back register file with per-lane partial writes, lane-accurate read
// bypass and a per-register busy scoreboard. Register 0 reads as zero and is never busy.
module regfile_lane_sb #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   rd_addr1,
  input  logic [ADDR_W-1:0]   rd_addr2,
  output logic [DATA_W-1:0]   rd_data1,
  output logic [DATA_W-1:0]   rd_data2,
  output logic                rd_busy1,
  output logic                rd_busy2,
  input  logic                wa_en,
  input  logic [ADDR_W-1:0]   wa_addr,
  input  logic [DATA_W-1:0]   wa_data,
  input  logic [2:0]          wa_ppp,
  input  logic                wb_en,
  input  logic [ADDR_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic [2:0]          wb_ppp,
  input  logic                iss_en,
  input  logic [ADDR_W-1:0]   iss_addr,
  output logic [NUM_REGS-1:0] busy_vec
);

  localparam int HALF   = DATA_W / 2;
  localparam int NBYTES = DATA_W / 8;

  function automatic logic [DATA_W-1:0] lane_mask(input logic [2:0] ppp);
    logic [DATA_W-1:0] m;
    m = '0;
    case (ppp)
      3'b000:  m = '1;
      3'b001:  m = {{HALF{1'b1}}, {HALF{1'b0}}};
      3'b010:  m = {{HALF{1'b0}}, {HALF{1'b1}}};
      3'b011:  for (int k = 1; k < NBYTES; k += 2) m[8*k +: 8] = 8'hFF;
      3'b100:  for (int k = 0; k < NBYTES; k += 2) m[8*k +: 8] = 8'hFF;
      default: m = '0;
    endcase
    return m;
  endfunction

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_v,
                                              input logic [DATA_W-1:0] m,
                                              input logic [DATA_W-1:0] d);
    return (old_v & ~m) | (d & m);
  endfunction

  // Writable/readable register: nonzero and inside the implemented range.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a != '0) && ({{(32-ADDR_W){1'b0}}, a} < 32'(NUM_REGS));
  endfunction

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic [DATA_W-1:0]   w_regs_next [NUM_REGS];
  logic [NUM_REGS-1:0] w_busy_next;
  logic                w_wa_ok, w_wb_ok, w_iss_ok;
  logic [DATA_W-1:0]   w_mask_a, w_mask_b;

  assign w_wa_ok  = wa_en && addr_ok(wa_addr);
  assign w_wb_ok  = wb_en && addr_ok(wb_addr);
  assign w_iss_ok = iss_en && addr_ok(iss_addr);
  assign w_mask_a = lane_mask(wa_ppp);
  assign w_mask_b = lane_mask(wb_ppp);

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    logic w_hit_a, w_hit_b, w_hit_i;
    assign w_hit_a = w_wa_ok && (wa_addr == ADDR_W'(g));
    assign w_hit_b = w_wb_ok && (wb_addr == ADDR_W'(g));
    assign w_hit_i = w_iss_ok && (iss_addr == ADDR_W'(g));
    // Port B merged last so it wins on overlapping lanes; an empty mask still clears busy.
    assign w_regs_next[g] = merge(merge(r_regs[g], w_hit_a ? w_mask_a : '0, wa_data),
                                  w_hit_b ? w_mask_b : '0, wb_data);
    assign w_busy_next[g] = w_hit_i | (r_busy[g] & ~(w_hit_a | w_hit_b));

    // Register storage and busy bit update
    always_ff @(posedge clk) begin
      if (reset) begin
        r_regs[g] <= '0;
        r_busy[g] <= 1'b0;
      end else begin
        r_regs[g] <= w_regs_next[g];
        r_busy[g] <= w_busy_next[g];
      end
    end
  end

  logic                w_ra1_ok, w_ra2_ok;
  logic                w_r1_hit_a, w_r1_hit_b, w_r2_hit_a, w_r2_hit_b;
  logic [DATA_W-1:0]   w_r1_stored, w_r2_stored;

  assign w_ra1_ok    = addr_ok(rd_addr1);
  assign w_ra2_ok    = addr_ok(rd_addr2);
  assign w_r1_hit_a  = w_wa_ok && (wa_addr == rd_addr1);
  assign w_r1_hit_b  = w_wb_ok && (wb_addr == rd_addr1);
  assign w_r2_hit_a  = w_wa_ok && (wa_addr == rd_addr2);
  assign w_r2_hit_b  = w_wb_ok && (wb_addr == rd_addr2);
  assign w_r1_stored = w_ra1_ok ? r_regs[rd_addr1] : '0;
  assign w_r2_stored = w_ra2_ok ? r_regs[rd_addr2] : '0;

  // Bypass only the lanes actually being written this cycle.
  assign rd_data1 = merge(merge(w_r1_stored, w_r1_hit_a ? w_mask_a : '0, wa_data),
                          w_r1_hit_b ? w_mask_b : '0, wb_data);
  assign rd_data2 = merge(merge(w_r2_stored, w_r2_hit_a ? w_mask_a : '0, wa_data),
                          w_r2_hit_b ? w_mask_b : '0, wb_data);

  assign rd_busy1 = w_ra1_ok && r_busy[rd_addr1] &&
                    !((w_r1_hit_a && (wa_ppp == 3'b000)) || (w_r1_hit_b && (wb_ppp == 3'b000)));
  assign rd_busy2 = w_ra2_ok && r_busy[rd_addr2] &&
                    !((w_r2_hit_a && (wa_ppp == 3'b000)) || (w_r2_hit_b && (wb_ppp == 3'b000)));

  assign busy_vec = r_busy;

endmodule

// File: doc/regfile_lane_sb.md
Name: regfile_lane_sb

Overview:
- Parametrised successor to the single-write register file.
- Adds two write-back ports, lane-accurate read bypass, and a per-register busy scoreboard for hazard detection.
- Keeps participation-bit (ppp) partial writes. Sits between decode (read/issue) and write-back in the pipeline.

Parameters:
- DATA_W, 64, register width in bits; must be a multiple of 16.
- NUM_REGS, 32, number of registers; register 0 is hardwired to zero.
- ADDR_W, 5, address width; NUM_REGS must be ≤ 2**ADDR_W.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- rd_addr1  in  ADDR_W  read port 1 address
- rd_addr2  in  ADDR_W  read port 2 address
- rd_data1  out  DATA_W  read port 1 data (combinational)
- rd_data2  out  DATA_W  read port 2 data (combinational)
- rd_busy1  out  1  register at rd_addr1 has an outstanding write
- rd_busy2  out  1  register at rd_addr2 has an outstanding write
- wa_en  in  1  write port A enable
- wa_addr  in  ADDR_W  write port A address
- wa_data  in  DATA_W  write port A data
- wa_ppp  in  3  write port A participation
- wb_en  in  1  write port B enable
- wb_addr  in  ADDR_W  write port B address
- wb_data  in  DATA_W  write port B data
- wb_ppp  in  3  write port B participation
- iss_en  in  1  issue: mark destination busy
- iss_addr  in  ADDR_W  issued destination register
- busy_vec  out  NUM_REGS  scoreboard state, bit i = register i busy

Behaviour:
- Clock and reset: clk; reset is synchronous, active-high.
- Reset: all registers go to 0; busy_vec goes to 0. Reset mid-operation discards any pending write or issue in that cycle.
- Lane mask from ppp, with "half" = DATA_W/2 and "byte k" = bits [8k+7:8k]:
  - 000: all bits.
  - 001: upper half.
  - 010: lower half.
  - 011: odd bytes (1, 3, 5, …).
  - 100: even bytes (0, 2, 4, …).
  - 101–111: empty mask, no write, but the write still clears busy.
- Write (posedge clk): for each enabled port with addr ≠ 0 and addr < NUM_REGS, masked bits update and unmasked bits are retained.
- Same address on both ports: lanes are merged. Where masks overlap, port B wins.
- Address 0: writes are ignored; reads return 0; never busy.
- Read is combinational, with a lane-accurate bypass. For each bit of the addressed register:
  - If port B writes that bit this cycle, return wb_data.
  - Else if port A writes it, return wa_data.
  - Else return the stored value.
  - Unmasked lanes never bypass; this intentionally changes the old whole-word bypass.
- Out-of-range read address (≥ NUM_REGS): returns 0, busy reads 0.
- Scoreboard (posedge clk):
  - busy[i] is cleared when wa_en or wb_en writes to i.
  - busy[i] is set when iss_en and iss_addr = i.
  - Set and clear on the same register in the same cycle: set wins (a new producer was issued).
  - iss_addr 0 or out of range: ignored.
  - Re-issuing an already-busy register keeps it busy (no counting).
- rd_busyN = busy[rd_addrN], except it reads 0 if a write to rd_addrN is enabled this cycle with ppp 000. Partial writes do not clear the combinational rd_busy early; the registered busy bit still clears on the next edge.
- Latency: write visible through bypass in the same cycle, and from the array on the next cycle. Busy set or clear takes effect after one edge.
- Outputs are never X after the first reset edge.

Test Plan:
1. Reset, then read r5 on both ports -> rd_data = 0, busy_vec = 0.
2. Write r3 = 0x1122334455667788 with ppp 000, then write port A r3 data 0xFFFFFFFFFFFFFFFF with ppp 011 -> next-cycle read r3 = 0xFF22FF44FF66FF88. During the second write cycle, rd_data1 (r3) shows the same value via bypass.
3. Same cycle:
   - Port A r7 = 0xAAAAAAAAAAAAAAAA, ppp 000.
   - Port B r7 = 0x5555555555555555, ppp 010.
   - Expected: r7 = 0xAAAAAAAA55555555.
   - Also write r0 = 0x1 -> r0 reads 0.
4. Scoreboard sequence:
   - Issue r9 -> busy_vec[9] = 1 and rd_busy1 = 1 (rd_addr1 = 9) next cycle.
   - Write back r9 ppp 000 -> rd_busy1 = 0 combinationally that cycle; busy_vec[9] = 0 after the edge.
5. Same cycle issue r4 and write back r4 -> busy_vec[4] = 1 after the edge. Write with ppp 110 -> data unchanged, busy cleared.
6. Set r2 = 0x1234, issue r2, assert reset for one cycle -> r2 = 0, busy_vec = 0. Read out-of-range address with NUM_REGS = 24 -> 0.
